// File: rtl/vga_timing_gen.sv
// Parameter-driven VGA raster timing generator: free-running pixel/line counters
// decoded into DE, sync pins and frame/line markers, with an optional output delay line.
module vga_timing_gen #(
    parameter int H_DISPW = 640,
    parameter int H_FP    = 16,
    parameter int H_PW    = 96,
    parameter int H_BP    = 48,
    parameter bit H_POL   = 1'b0,
    parameter int V_DISPW = 480,
    parameter int V_FP    = 10,
    parameter int V_PW    = 2,
    parameter int V_BP    = 33,
    parameter bit V_POL   = 1'b0,
    parameter int CNT_W   = 11,
    parameter int OUT_DLY = 0
) (
    input  logic             PCLK_I,
    input  logic             RST_I,
    input  logic             CE_I,
    input  logic             FRAME_RST_I,
    output logic             DE_O,
    output logic             HSYNC_O,
    output logic             VSYNC_O,
    output logic             SOF_O,
    output logic             SOL_O,
    output logic [CNT_W-1:0] HCNT_O,
    output logic [CNT_W-1:0] VCNT_O
);

    localparam int HTOTAL = H_DISPW + H_FP + H_PW + H_BP;
    localparam int VTOTAL = V_DISPW + V_FP + V_PW + V_BP;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HTOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VTOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_DISPW);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_DISPW);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_DISPW + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_DISPW + H_FP + H_PW - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_DISPW + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_DISPW + V_FP + V_PW);

    typedef struct packed {
        logic             de;
        logic             hsync;
        logic             vsync;
        logic             sof;
        logic             sol;
        logic [CNT_W-1:0] hcnt;
        logic [CNT_W-1:0] vcnt;
    } stage_t;

    // Idle pipeline content: sync pins parked at their deasserted level.
    function automatic stage_t idle_stage();
        stage_t s;
        s.de    = 1'b0;
        s.hsync = ~H_POL;
        s.vsync = ~V_POL;
        s.sof   = 1'b0;
        s.sol   = 1'b0;
        s.hcnt  = CNT_ZERO;
        s.vcnt  = CNT_ZERO;
        return s;
    endfunction

    logic [CNT_W-1:0] h_r;
    logic [CNT_W-1:0] v_r;
    logic [CNT_W-1:0] h_nxt_s;
    logic [CNT_W-1:0] v_nxt_s;
    logic             hs_act_s;
    logic             vs_act_s;
    stage_t           dec_s;
    stage_t           pipe_r [OUT_DLY+1];

    // Next raster position: restart, line wrap with line advance, or next pixel.
    always_comb begin
        h_nxt_s = h_r;
        v_nxt_s = v_r;
        if (FRAME_RST_I) begin
            h_nxt_s = CNT_ZERO;
            v_nxt_s = CNT_ZERO;
        end else if (h_r == H_LAST) begin
            h_nxt_s = CNT_ZERO;
            if (v_r == V_LAST) begin
                v_nxt_s = CNT_ZERO;
            end else begin
                v_nxt_s = v_r + CNT_ONE;
            end
        end else begin
            h_nxt_s = h_r + CNT_ONE;
        end
    end

    // Raster counters; reset parks them on the last pixel so the first edge lands on (0,0).
    always_ff @(posedge PCLK_I or negedge RST_I) begin
        if (!RST_I) begin
            h_r <= H_LAST;
            v_r <= V_LAST;
        end else if (CE_I) begin
            h_r <= h_nxt_s;
            v_r <= v_nxt_s;
        end
    end

    // Decode of the current position; vsync edges are aligned to the hsync start column.
    always_comb begin
        dec_s    = idle_stage();
        hs_act_s = (h_r >= HS_START) && (h_r <= HS_LAST);
        vs_act_s = ((v_r == VS_START) && (h_r >= HS_START)) ||
                   ((v_r > VS_START) && (v_r < VS_END)) ||
                   ((v_r == VS_END) && (h_r < HS_START));
        dec_s.de    = (h_r < H_ACT) && (v_r < V_ACT);
        dec_s.hsync = H_POL ? hs_act_s : ~hs_act_s;
        dec_s.vsync = V_POL ? vs_act_s : ~vs_act_s;
        dec_s.sof   = (h_r == CNT_ZERO) && (v_r == CNT_ZERO);
        dec_s.sol   = (h_r == CNT_ZERO);
        dec_s.hcnt  = h_r;
        dec_s.vcnt  = v_r;
    end

    // Output pipeline: stage 0 registers the decode, further stages add OUT_DLY cycles.
    always_ff @(posedge PCLK_I or negedge RST_I) begin
        if (!RST_I) begin
            for (int i = 0; i <= OUT_DLY; i++) begin
                pipe_r[i] <= idle_stage();
            end
        end else if (CE_I) begin
            pipe_r[0] <= dec_s;
            for (int i = 1; i <= OUT_DLY; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign DE_O    = pipe_r[OUT_DLY].de;
    assign HSYNC_O = pipe_r[OUT_DLY].hsync;
    assign VSYNC_O = pipe_r[OUT_DLY].vsync;
    assign SOF_O   = pipe_r[OUT_DLY].sof;
    assign SOL_O   = pipe_r[OUT_DLY].sol;
    assign HCNT_O  = pipe_r[OUT_DLY].hcnt;
    assign VCNT_O  = pipe_r[OUT_DLY].vcnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default, 3-stage delay, tiny raster)
// checked against a linear-position reference model plus directed vectors.
module tb_vga_timing_gen;

    logic clk;
    logic rst_n;
    logic ce;
    logic frst;

    logic [2:0]  de_w, hs_w, vs_w, sof_w, sol_w;
    logic [10:0] h0_w, v0_w, h3_w, v3_w;
    logic [4:0]  hc2_w, vc2_w;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        sof;
        logic        sol;
        logic [15:0] h;
        logic [15:0] v;
    } exp_t;

    typedef struct {
        int hd, hf, hp, hb, hpol, vd, vf, vp, vb, vpol, dly;
    } cfg_t;

    typedef struct {
        bit   rst_n;
        bit   ce;
        bit   frst;
        exp_t exp;
    } vec_t;

    cfg_t cfg [3];
    int   pos [3];
    exp_t pipe [3][8];
    int   checks = 0;
    int   failures = 0;

    vga_timing_gen #(.OUT_DLY(0)) dut0 (
        .PCLK_I(clk), .RST_I(rst_n), .CE_I(ce), .FRAME_RST_I(frst),
        .DE_O(de_w[0]), .HSYNC_O(hs_w[0]), .VSYNC_O(vs_w[0]), .SOF_O(sof_w[0]),
        .SOL_O(sol_w[0]), .HCNT_O(h0_w), .VCNT_O(v0_w));

    vga_timing_gen #(.OUT_DLY(3)) dut3 (
        .PCLK_I(clk), .RST_I(rst_n), .CE_I(ce), .FRAME_RST_I(frst),
        .DE_O(de_w[1]), .HSYNC_O(hs_w[1]), .VSYNC_O(vs_w[1]), .SOF_O(sof_w[1]),
        .SOL_O(sol_w[1]), .HCNT_O(h3_w), .VCNT_O(v3_w));

    vga_timing_gen #(.H_DISPW(8), .H_FP(2), .H_PW(3), .H_BP(3), .H_POL(1'b1),
                     .V_DISPW(6), .V_FP(2), .V_PW(2), .V_BP(2), .V_POL(1'b1),
                     .CNT_W(5), .OUT_DLY(2)) dut_s (
        .PCLK_I(clk), .RST_I(rst_n), .CE_I(ce), .FRAME_RST_I(frst),
        .DE_O(de_w[2]), .HSYNC_O(hs_w[2]), .VSYNC_O(vs_w[2]), .SOF_O(sof_w[2]),
        .SOL_O(sol_w[2]), .HCNT_O(hc2_w), .VCNT_O(vc2_w));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(bit de, bit hs, bit vs, bit sof, bit sol, int h, int v);
        exp_t e;
        e.de = de; e.hs = hs; e.vs = vs; e.sof = sof; e.sol = sol;
        e.h = 16'(h); e.v = 16'(v);
        return e;
    endfunction

    function automatic int htot(int id);
        return cfg[id].hd + cfg[id].hf + cfg[id].hp + cfg[id].hb;
    endfunction

    function automatic int vtot(int id);
        return cfg[id].vd + cfg[id].vf + cfg[id].vp + cfg[id].vb;
    endfunction

    function automatic exp_t idle_of(int id);
        return mk(0, cfg[id].hpol == 0, cfg[id].vpol == 0, 0, 0, 0, 0);
    endfunction

    // Outputs expected for linear raster position p (p = v*HTOTAL + h).
    function automatic exp_t model_out(int id, int p);
        int ht, h, v, hs0, vs0, vs1;
        bit hs_a, vs_a;
        ht   = htot(id);
        h    = p % ht;
        v    = p / ht;
        hs0  = cfg[id].hd + cfg[id].hf;
        hs_a = (h >= hs0) && (h < hs0 + cfg[id].hp);
        vs0  = (cfg[id].vd + cfg[id].vf) * ht + hs0;
        vs1  = vs0 + cfg[id].vp * ht;
        vs_a = (p >= vs0) && (p < vs1);
        return mk((h < cfg[id].hd) && (v < cfg[id].vd),
                  cfg[id].hpol != 0 ? hs_a : !hs_a,
                  cfg[id].vpol != 0 ? vs_a : !vs_a,
                  p == 0, h == 0, h, v);
    endfunction

    task automatic model_reset();
        for (int id = 0; id < 3; id++) begin
            pos[id] = htot(id) * vtot(id) - 1;
            for (int k = 0; k < 8; k++) pipe[id][k] = idle_of(id);
        end
    endtask

    task automatic model_edge(int id);
        for (int k = 7; k > 0; k--) pipe[id][k] = pipe[id][k-1];
        pipe[id][0] = model_out(id, pos[id]);
        pos[id] = frst ? 0 : (pos[id] + 1) % (htot(id) * vtot(id));
    endtask

    function automatic exp_t actual(int id);
        case (id)
            0:       return mk(de_w[0], hs_w[0], vs_w[0], sof_w[0], sol_w[0], int'(h0_w), int'(v0_w));
            1:       return mk(de_w[1], hs_w[1], vs_w[1], sof_w[1], sol_w[1], int'(h3_w), int'(v3_w));
            default: return mk(de_w[2], hs_w[2], vs_w[2], sof_w[2], sol_w[2], int'(hc2_w), int'(vc2_w));
        endcase
    endfunction

    task automatic check_exp(string name, exp_t a, exp_t e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got de=%0d hs=%0d vs=%0d sof=%0d sol=%0d h=%0d v=%0d, want de=%0d hs=%0d vs=%0d sof=%0d sol=%0d h=%0d v=%0d",
                     name, a.de, a.hs, a.vs, a.sof, a.sol, a.h, a.v,
                     e.de, e.hs, e.vs, e.sof, e.sol, e.h, e.v);
        end
    endtask

    task automatic check_int(string name, int a, int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, a, e);
        end
    endtask

    // One clock: advance the model on enabled edges, then compare every instance.
    task automatic step();
        @(posedge clk);
        if (rst_n && ce) begin
            for (int id = 0; id < 3; id++) model_edge(id);
        end
        #1;
        for (int id = 0; id < 3; id++)
            check_exp($sformatf("dut%0d_model", id), actual(id), pipe[id][cfg[id].dly]);
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int id = 0; id < 3; id++)
            check_exp($sformatf("async_idle%0d", id), actual(id), idle_of(id));
    endtask

    vec_t tbl [10];

    initial begin
        int t, t_rise0, t_rise1, run, found, lowcnt, bad_hs, bad_de;
        bit prev;

        cfg[0] = '{640, 16, 96, 48, 0, 480, 10, 2, 33, 0, 0};
        cfg[1] = '{640, 16, 96, 48, 0, 480, 10, 2, 33, 0, 3};
        cfg[2] = '{8, 2, 3, 3, 1, 6, 2, 2, 2, 1, 2};

        rst_n = 1'b1; ce = 1'b0; frst = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int id = 0; id < 3; id++)
            check_exp($sformatf("reset_idle%0d", id), actual(id), idle_of(id));

        // Directed start-up vectors for the default instance.
        tbl[0] = '{1'b0, 1'b1, 1'b0, mk(0, 1, 1, 0, 0, 0, 0)};
        tbl[1] = '{1'b1, 1'b1, 1'b0, mk(0, 1, 1, 0, 0, 799, 524)};
        tbl[2] = '{1'b1, 1'b1, 1'b0, mk(1, 1, 1, 1, 1, 0, 0)};
        tbl[3] = '{1'b1, 1'b0, 1'b0, mk(1, 1, 1, 1, 1, 0, 0)};
        tbl[4] = '{1'b1, 1'b1, 1'b0, mk(1, 1, 1, 0, 0, 1, 0)};
        tbl[5] = '{1'b1, 1'b1, 1'b1, mk(1, 1, 1, 0, 0, 2, 0)};
        tbl[6] = '{1'b1, 1'b1, 1'b0, mk(1, 1, 1, 1, 1, 0, 0)};
        tbl[7] = '{1'b1, 1'b0, 1'b1, mk(1, 1, 1, 1, 1, 0, 0)};
        tbl[8] = '{1'b1, 1'b1, 1'b0, mk(1, 1, 1, 0, 0, 1, 0)};
        tbl[9] = '{1'b1, 1'b1, 1'b0, mk(1, 1, 1, 0, 0, 2, 0)};
        for (int i = 0; i < 10; i++) begin
            rst_n = tbl[i].rst_n; ce = tbl[i].ce; frst = tbl[i].frst;
            step();
            check_exp($sformatf("vec%0d", i), actual(0), tbl[i].exp);
        end
        frst = 1'b0;

        // Randomized enable / restart traffic with occasional mid-frame resets.
        for (int i = 0; i < 3000; i++) begin
            ce   = ($urandom_range(0, 3) != 0);
            frst = ($urandom_range(0, 199) == 0);
            step();
            if (i % 1000 == 500) begin
                frst = 1'b0;
                async_reset();
                step();
                step();
                rst_n = 1'b1;
            end
        end
        ce = 1'b1; frst = 1'b0;

        // Hsync / DE placement over one full default line.
        lowcnt = 0; bad_hs = 0; bad_de = 0;
        for (int i = 0; i < 800; i++) begin
            step();
            if (hs_w[0] == 1'b0) lowcnt++;
            if ((hs_w[0] == 1'b0) != (h0_w >= 656 && h0_w <= 751)) bad_hs++;
            if (de_w[0] != (h0_w < 640 && v0_w < 480)) bad_de++;
        end
        check_int("hsync_low_clocks", lowcnt, 96);
        check_int("hsync_position", bad_hs, 0);
        check_int("de_position", bad_de, 0);

        // Alternating enable: line period and SOL width in clocks.
        t = 0; t_rise0 = -1; t_rise1 = -1; prev = sol_w[0];
        while (t_rise1 < 0 && t < 4000) begin
            ce = (t % 2 == 0);
            step();
            if (sol_w[0] && !prev) begin
                if (t_rise0 < 0) t_rise0 = t; else t_rise1 = t;
            end
            prev = sol_w[0];
            t++;
        end
        check_int("sol_found", (t_rise1 >= 0) ? 1 : 0, 1);
        run = 1;
        while (sol_w[0] && run < 10) begin
            ce = (t % 2 == 0);
            step();
            if (sol_w[0]) run++;
            t++;
        end
        check_int("line_period_clocks", t_rise1 - t_rise0, 1600);
        check_int("sol_high_clocks", run, 2);
        ce = 1'b1;

        // Vsync placement and width on the small raster (active-high pins).
        found = 0; prev = vs_w[2];
        for (int i = 0; i < 400 && found == 0; i++) begin
            step();
            if (vs_w[2] && !prev) found = 1;
            prev = vs_w[2];
        end
        check_int("vsync_rise_found", found, 1);
        check_int("vsync_rise_h", int'(hc2_w), 10);
        check_int("vsync_rise_v", int'(vc2_w), 8);
        run = 0;
        while (vs_w[2] && run < 100) begin
            step();
            run++;
        end
        check_int("vsync_width_clocks", run, 32);
        check_int("vsync_fall_h", int'(hc2_w), 10);
        check_int("vsync_fall_v", int'(vc2_w), 10);

        // Frame restart on the delayed instance while its counter sits at (300,1).
        frst = 1'b1;
        step();
        frst = 1'b0;
        found = 0;
        for (int i = 0; i < 2000 && found == 0; i++) begin
            step();
            if (h3_w == 11'd296 && v3_w == 11'd1) found = 1;
        end
        check_int("restart_point_found", found, 1);
        frst = 1'b1;
        step();
        frst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i == 3) check_exp("frst_lat_minus1", actual(1), model_out(1, htot(1) + 300));
        end
        check_exp("frst_lat4", actual(1), mk(1, 1, 1, 1, 1, 0, 0));

        // Asynchronous reset mid-line, then the restart latency of the delayed instance.
        found = 0;
        for (int i = 0; i < 1000 && found == 0; i++) begin
            step();
            if (h3_w == 11'd700) found = 1;
        end
        check_int("hcnt700_found", found, 1);
        async_reset();
        step();
        step();
        rst_n = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            step();
            if (e == 4) check_int("first_pixel_edge4_de", int'(de_w[1]), 0);
        end
        check_exp("first_pixel_edge5", actual(1), mk(1, 1, 1, 1, 1, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters (name, default, meaning): H_DISPW 640 active pixels; H_FP 16 front porch; H_PW 96 sync width; H_BP 48 back porch; H_POL 0 (0 = sync pin low when asserted).
REQ-002 Parameters: V_DISPW 480 active lines; V_FP 10; V_PW 2; V_BP 33; V_POL 0; CNT_W 11 counter width; OUT_DLY 0 extra output pipeline stages (0..7).
REQ-003 Derived values: HTOTAL = H_DISPW+H_FP+H_PW+H_BP; VTOTAL = V_DISPW+V_FP+V_PW+V_BP; CNT_W SHALL hold max(HTOTAL,VTOTAL)-1.
REQ-004 Ports (name, direction, width, meaning):
- PCLK_I, in, 1, pixel clock, single clock domain.
- RST_I, in, 1, asynchronous active-low reset.
- CE_I, in, 1, pixel clock enable.
- FRAME_RST_I, in, 1, synchronous restart to pixel (0,0).
- DE_O, out, 1, 1 = active video.
- HSYNC_O, out, 1, horizontal sync pin, polarity per H_POL.
- VSYNC_O, out, 1, vertical sync pin, polarity per V_POL.
- SOF_O, out, 1, start of frame, high at pixel (0,0).
- SOL_O, out, 1, start of line, high at HCNT=0 of every line.
- HCNT_O, out, CNT_W, pixel column.
- VCNT_O, out, CNT_W, line number.

Function
REQ-005 Internal h counter SHALL count 0..HTOTAL-1 and wrap to 0; v counter SHALL increment only on h wrap and SHALL wrap VTOTAL-1 -> 0.
REQ-006 Both counters and all pipeline stages SHALL advance only when CE_I=1; when CE_I=0 every register and output SHALL hold.
REQ-007 Active-video decode: active = (h < H_DISPW) and (v < V_DISPW).
REQ-008 Hsync decode: asserted for h in [H_DISPW+H_FP, H_DISPW+H_FP+H_PW).
REQ-009 Vsync changes only at h = H_DISPW+H_FP; it is asserted from (v = V_DISPW+V_FP, that h) up to but excluding (v = V_DISPW+V_FP+V_PW, that h).
REQ-010 Sync pin level: pin = asserted when POL=1, pin = not asserted when POL=0.
REQ-011 SOF_O SHALL be high for exactly one enabled cycle at h=0,v=0; SOL_O high for one enabled cycle at h=0 of every line.
REQ-012 All outputs, including HCNT_O and VCNT_O, SHALL be registered and mutually aligned.
REQ-013 Latency: all outputs SHALL reflect the counter state LAT = 1+OUT_DLY enabled cycles earlier.
REQ-014 FRAME_RST_I=1 with CE_I=1: the next counter state SHALL be (0,0), regardless of current position. The pipeline is not flushed, so (0,0) appears at the outputs LAT enabled cycles later.
REQ-015 FRAME_RST_I with CE_I=0 SHALL be ignored.
REQ-016 FRAME_RST_I asserted while counters are at HTOTAL-1,VTOTAL-1 SHALL be indistinguishable from natural wrap.
REQ-017 Generated timing SHALL be purely parameter-driven; no runtime mode inputs.

Reset
REQ-018 RST_I=0 SHALL immediately, without a clock edge, force the internal counters to (HTOTAL-1, VTOTAL-1) and every pipeline stage to the idle state.
REQ-019 Idle state: DE_O=0, SOF_O=0, SOL_O=0, HCNT_O=0, VCNT_O=0, HSYNC_O=H_POL?0:1, VSYNC_O=V_POL?0:1.
REQ-020 Reset asserted mid-frame SHALL take effect at once. After deassertion, the first enabled edge SHALL produce counter state (0,0).
REQ-021 RST_I SHALL dominate CE_I and FRAME_RST_I.

Verification
REQ-022 Defaults, OUT_DLY=0, CE_I=1; release RST_I -> first edge counter (0,0); second edge DE_O=1, SOF_O=1, SOL_O=1, HCNT_O=0, VCNT_O=0; frame repeats every 420000 clocks.
REQ-023 Defaults, any line -> HSYNC_O=0 exactly while HCNT_O is 656..751; DE_O=1 exactly while HCNT_O<640 and VCNT_O<480.
REQ-024 Defaults, VSYNC -> VSYNC_O falls at (VCNT_O=490, HCNT_O=656), rises at (492, 656), and is low for 1600 clocks.
REQ-025 CE_I alternating 1,0 -> all outputs hold on CE_I=0 cycles; line period 1600 clocks; SOL_O high for one enabled cycle, i.e. 2 clocks.
REQ-026 OUT_DLY=3; FRAME_RST_I pulsed at counter (300,100) -> outputs reach HCNT_O=0, VCNT_O=0, SOF_O=1 exactly 4 enabled cycles after the pulse edge.
REQ-027 OUT_DLY=3; RST_I low mid-line (HCNT_O=700) -> all outputs go idle with no clock edge needed; restart as in REQ-022, first active pixel after 5 edges.
